// File: rtl/debouncer_pkg.sv
// -----------------------------------------------------------------------------
// debouncer_pkg
//   Shared constants and helpers for the debouncer and its synchroniser.
//   - MIN_SYNC_STAGES   : shortest synchroniser chain.
//   - MIN_STABLE_CYCLES : shortest qualification window.
//   - cnt_width()       : qualification counter width, never below 1 bit.
// -----------------------------------------------------------------------------
package debouncer_pkg;

    localparam int MIN_SYNC_STAGES   = 2;
    localparam int MIN_STABLE_CYCLES = 1;

    // Holds 0 .. stable_cycles. A 1-cycle window still needs a real 1-bit
    // register, so the result is clamped at one bit.
    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debouncer_sync.sv
// -----------------------------------------------------------------------------
// debouncer_sync
//   Multi-flop synchroniser bringing an asynchronous level into i_clk's domain.
//   Parameters:
//     p_STAGES : chain length (clamped to at least MIN_SYNC_STAGES)
//     p_INIT   : value every flop loads on reset
//   Ports:
//     i_clk   : rising-edge clock
//     i_rst   : synchronous active-high reset
//     i_async : raw asynchronous input
//     o_sync  : output of the last stage
// -----------------------------------------------------------------------------
module debouncer_sync
    import debouncer_pkg::*;
#(
    parameter int   p_STAGES = 2,
    parameter logic p_INIT   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    localparam int STAGES = (p_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : p_STAGES;

    // chain[0] is the metastable capture flop; chain[STAGES-1] is the clean output.
    logic [STAGES-1:0] chain;

    // NOTE: the reset is synchronous, so i_rst is tested inside the clocked
    // block and never appears in the sensitivity list.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            chain <= {STAGES{p_INIT}};
        end else begin
            // NOTE: non-blocking assignment, so each stage takes its
            // neighbour's pre-edge value and the chain shifts by exactly one.
            chain <= {chain[STAGES-2:0], i_async};
        end
    end

    assign o_sync = chain[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// -----------------------------------------------------------------------------
// debouncer
//   Synchronises and debounces a raw level (button, switch) into a clean,
//   clock-aligned level. A change on the synchronised input reaches o_level
//   only after it has differed from o_level for p_STABLE_CYCLES consecutive
//   cycles; shorter excursions are discarded.
//   Parameters:
//     p_STABLE_CYCLES : qualification window in cycles (>= 1)
//     p_SYNC_STAGES   : synchroniser length (>= 2)
//     p_INIT          : reset value of the synchroniser and of o_level
//   Ports:
//     i_clk    : rising-edge clock
//     i_rst    : synchronous active-high reset
//     i_signal : raw asynchronous level
//     o_level  : debounced level (registered)
//     o_busy   : high while a candidate change is being qualified
// -----------------------------------------------------------------------------
module debouncer
    import debouncer_pkg::*;
#(
    parameter int   p_STABLE_CYCLES = 16,
    parameter int   p_SYNC_STAGES   = 2,
    parameter logic p_INIT          = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_signal,
    output logic o_level,
    output logic o_busy
);

    localparam int STABLE = (p_STABLE_CYCLES < MIN_STABLE_CYCLES) ? MIN_STABLE_CYCLES
                                                                   : p_STABLE_CYCLES;
    localparam int               CNT_W    = cnt_width(STABLE);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(STABLE - 1);

    logic             sync_level;
    logic [CNT_W-1:0] cnt;

    debouncer_sync #(
        .p_STAGES (p_SYNC_STAGES),
        .p_INIT   (p_INIT)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_signal),
        .o_sync  (sync_level)
    );

    // cnt == 0 is IDLE, anything else is COUNTING; no separate state register.
    // The terminal compare commits the change and clears cnt on the same edge,
    // so the counter can never wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_level <= p_INIT;
            cnt     <= '0;
        end else if (sync_level == o_level) begin
            // Input agrees with the output (or bounced back): restart qualification.
            cnt <= '0;
        end else if (cnt == TERMINAL) begin
            o_level <= sync_level;
            cnt     <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Decoded straight from the counter register; with a 1-cycle window cnt
    // never leaves zero, so o_busy stays low.
    assign o_busy = (cnt != '0);

endmodule

// File: tb/tb_debouncer.sv
// -----------------------------------------------------------------------------
// tb_debouncer
//   Bench for debouncer. The main instance uses a 4-cycle window with a
//   2-stage synchroniser; a second instance with a 1-cycle window feeds a
//   falling-edge pulse detector built into the bench.
//   The reference model states the behaviour directly: the synchroniser is a
//   plain delay line of captured samples, and o_level flips once the last
//   N synchronised samples all disagree with it.
// -----------------------------------------------------------------------------
module tb_debouncer;

    localparam int   N    = 4;
    localparam int   ST   = 2;
    localparam logic INIT = 1'b0;

    logic clk = 1'b0;
    logic rst;
    logic sig;
    logic sig1;
    logic level;
    logic busy;
    logic level1;
    logic busy1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    debouncer #(
        .p_STABLE_CYCLES (N),
        .p_SYNC_STAGES   (ST),
        .p_INIT          (INIT)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_signal (sig),
        .o_level  (level),
        .o_busy   (busy)
    );

    debouncer #(
        .p_STABLE_CYCLES (1),
        .p_SYNC_STAGES   (2),
        .p_INIT          (1'b0)
    ) dut1 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_signal (sig1),
        .o_level  (level1),
        .o_busy   (busy1)
    );

    // ---------------- reference model ----------------
    logic sq[$];     // captured samples still in flight through the synchroniser
    logic hist[$];   // synchronised samples since the last output change or reset
    logic m_level;
    logic m_busy;
    logic q1[$];     // delay line for the 1-cycle instance
    logic m_level1;
    int   edge_no = 0;

    // Advance one clock edge and update the model with the inputs that were
    // present at that edge; returns 1 ns after the edge.
    task automatic tick();
        logic r0;
        logic in0;
        logic in1;
        logic s;
        logic flip;
        r0  = rst;
        in0 = sig;
        in1 = sig1;
        @(posedge clk);
        edge_no++;
        if (r0) begin
            sq = {};
            q1 = {};
            for (int i = 0; i < ST; i++) begin
                sq.push_back(INIT);
                q1.push_back(1'b0);
            end
            hist     = {};
            m_level  = INIT;
            m_busy   = 1'b0;
            m_level1 = 1'b0;
        end else begin
            s = sq.pop_front();
            sq.push_back(in0);
            hist.push_back(s);
            if (hist.size() > N) hist.delete(0);
            flip = (hist.size() == N);
            foreach (hist[i]) if (hist[i] == m_level) flip = 1'b0;
            if (flip) begin
                m_level = s;
                m_busy  = 1'b0;
                hist    = {};
            end else begin
                m_busy = (s != m_level);
            end
            m_level1 = q1.pop_front();
            q1.push_back(in1);
        end
        #1;
    endtask

    task automatic idle(input logic v, input int n);
        sig = v;
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int cap;
        int rise;
        rst  = 1'b1;
        sig  = 1'b1;
        sig1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (level !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: level=%b busy=%b, want level=0 busy=0", level, busy);
            end
        end
        rst  = 1'b0;
        cap  = edge_no + 1;
        rise = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (level !== m_level || busy !== m_busy) begin
                bad++;
                $display("FAIL reset_release: level=%b busy=%b, want %b %b", level, busy, m_level, m_busy);
            end
            if (rise < 0 && level === 1'b1) rise = edge_no;
        end
        total++;
        if (rise - cap !== N + ST - 1) begin
            bad++;
            $display("FAIL reset_latency: rise after %0d edges, want %0d", rise - cap, N + ST - 1);
        end
    endtask

    task automatic test_clean_step();
        int k;
        int off;
        idle(1'b0, 12);
        total++;
        if (level !== 1'b0) begin
            bad++;
            $display("FAIL step_settle: level=%b, want 0", level);
        end
        sig = 1'b1;
        k   = edge_no + 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            off = edge_no - k;
            total++;
            if (off >= 2 && off <= 4) begin
                if (busy !== 1'b1 || level !== 1'b0) begin
                    bad++;
                    $display("FAIL step_counting k+%0d: busy=%b level=%b, want 1 0", off, busy, level);
                end
            end else if (off >= 5) begin
                if (busy !== 1'b0 || level !== 1'b1) begin
                    bad++;
                    $display("FAIL step_done k+%0d: busy=%b level=%b, want 0 1", off, busy, level);
                end
            end else if (busy !== 1'b0 || level !== 1'b0) begin
                bad++;
                $display("FAIL step_sync k+%0d: busy=%b level=%b, want 0 0", off, busy, level);
            end
        end
    endtask

    task automatic test_glitch();
        int   rises;
        logic prev;
        idle(1'b0, 12);
        // 3-cycle pulse: one short of the window, must vanish
        sig = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        sig = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (level !== 1'b0 || busy !== m_busy) begin
                bad++;
                $display("FAIL glitch3: level=%b busy=%b, want 0 %b", level, busy, m_busy);
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL glitch3_busy: busy=%b, want 0", busy);
        end
        // 4-cycle pulse: exactly the window, accepted once, then a 4-cycle low drops it
        rises = 0;
        prev  = level;
        sig   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 4) sig = 1'b0;
            tick();
            total++;
            if (level !== m_level || busy !== m_busy) begin
                bad++;
                $display("FAIL glitch4: level=%b busy=%b, want %b %b", level, busy, m_level, m_busy);
            end
            if (!prev && level === 1'b1) rises++;
            prev = level;
        end
        total++;
        if (rises !== 1 || level !== 1'b0) begin
            bad++;
            $display("FAIL glitch4_once: rises=%0d level=%b, want 1 0", rises, level);
        end
    endtask

    task automatic test_bounce();
        logic pat[6];
        int   rises;
        int   rise;
        int   cap;
        logic prev;
        pat   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        idle(1'b0, 12);
        rises = 0;
        rise  = -1;
        cap   = -1;
        prev  = level;
        for (int i = 0; i < 18; i++) begin
            sig = (i < 6) ? pat[i] : 1'b1;
            tick();
            if (i == 5) cap = edge_no;
            total++;
            if (level !== m_level || busy !== m_busy) begin
                bad++;
                $display("FAIL bounce: level=%b busy=%b, want %b %b", level, busy, m_level, m_busy);
            end
            if (!prev && level === 1'b1) begin
                rises++;
                rise = edge_no;
            end
            prev = level;
        end
        total++;
        if (rises !== 1 || rise - cap !== N + ST - 1) begin
            bad++;
            $display("FAIL bounce_rise: rises=%0d delay=%0d, want 1 %0d", rises, rise - cap, N + ST - 1);
        end
    endtask

    task automatic test_reset_mid();
        int cap;
        int rise;
        idle(1'b0, 12);
        sig = 1'b1;
        // capture edge, one sync edge, then two counting edges: cnt == 2
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (busy !== 1'b1 || level !== 1'b0) begin
            bad++;
            $display("FAIL midcount_pre: busy=%b level=%b, want 1 0", busy, level);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || level !== 1'b0) begin
            bad++;
            $display("FAIL midcount_reset: busy=%b level=%b, want 0 0", busy, level);
        end
        cap  = edge_no + 1;
        rise = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rise < 0 && level === 1'b1) rise = edge_no;
        end
        total++;
        if (rise - cap !== N + ST - 1) begin
            bad++;
            $display("FAIL midcount_latency: rise after %0d edges, want %0d", rise - cap, N + ST - 1);
        end
    endtask

    task automatic test_random();
        int run;
        run = 0;
        for (int i = 0; i < 800; i++) begin
            if (run == 0) begin
                sig = 1'($urandom_range(0, 1));
                run = int'($urandom_range(1, 7));
            end
            run--;
            rst = ($urandom_range(0, 79) == 0);
            tick();
            total++;
            if (level !== m_level || busy !== m_busy) begin
                bad++;
                $display("FAIL random @%0d: level=%b busy=%b, want %b %b", edge_no, level, busy, m_level, m_busy);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_chain();
        int   falls;
        int   hi;
        int   lo;
        logic prev;
        falls = 0;
        prev  = level1;
        for (int p = 0; p < 6; p++) begin
            hi = (p < 5) ? int'($urandom_range(1, 4)) : 0;
            lo = int'($urandom_range(2, 5));
            for (int i = 0; i < hi + lo; i++) begin
                sig1 = (i < hi);
                tick();
                total++;
                if (level1 !== m_level1 || busy1 !== 1'b0) begin
                    bad++;
                    $display("FAIL chain_lag: level=%b busy=%b, want %b 0", level1, busy1, m_level1);
                end
                if (prev && level1 === 1'b0) falls++;
                prev = level1;
            end
        end
        total++;
        if (falls !== 5) begin
            bad++;
            $display("FAIL chain_pulses: falls=%0d, want 5", falls);
        end
    endtask

    initial begin
        rst  = 1'b1;
        sig  = 1'b0;
        sig1 = 1'b0;
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_reset_mid();
        test_random();
        test_chain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
